// File: rtl/mux153_bus_arbiter_if.sv
// Request, select and strobe bundle between the requesters,
// the arbiter and the 74x153 pair feeding the shared bus.
interface mux153_bus_arbiter_if;
  logic [3:0] req;
  logic       sel_a;
  logic       sel_b;
  logic       enable_n;
  logic [3:0] grant;
  logic       busy;

  modport master (
    input  req,
    output sel_a,
    output sel_b,
    output enable_n,
    output grant,
    output busy
  );

  modport slave (
    output req,
    input  sel_a,
    input  sel_b,
    input  enable_n,
    input  grant,
    input  busy
  );
endinterface

// File: rtl/mux153_bus_arbiter.sv
// Round-robin arbiter for a 74x153 shared bus mux with
// break-before-make select/strobe sequencing.
module mux153_bus_arbiter #(
  parameter int SETTLE_CYCLES = 1,
  parameter int MAX_HOLD      = 8
) (
  input logic                  clk,
  input logic                  reset_n,
  mux153_bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    GRANT
  } state_t;

  localparam logic [3:0] S_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] H_LAST = 8'(MAX_HOLD - 1);
  localparam logic [7:0] H_MAX  = 8'(MAX_HOLD);

  state_t     state;
  state_t     state_d;
  logic [1:0] sel;
  logic [1:0] sel_d;
  logic [1:0] last;
  logic [1:0] last_d;
  logic [3:0] scnt;
  logic [3:0] scnt_d;
  logic [7:0] hcnt;
  logic [7:0] hcnt_d;
  logic       en_n;
  logic       en_n_d;
  logic [3:0] gnt;
  logic [3:0] gnt_d;
  logic       busy;
  logic       busy_d;
  logic [3:0] others;

  // First asserted request after l, wrapping modulo 4.
  function automatic logic [1:0] pick(
    input logic [3:0] r,
    input logic [1:0] l
  );
    logic [1:0] idx;
    logic [1:0] res;
    logic       found;
    res   = l;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = l + 2'(k);
      if (!found && r[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // The selects hold the owner throughout GRANT.
  assign others = bus.req & ~(4'b0001 << sel);

  // Next-state, select and counter decisions.
  always_comb begin
    state_d = state;
    sel_d   = sel;
    last_d  = last;
    scnt_d  = scnt;
    hcnt_d  = hcnt;
    unique case (state)
      IDLE: begin
        if (|bus.req) begin
          state_d = SETTLE;
          sel_d   = pick(bus.req, last);
          scnt_d  = '0;
        end
      end
      SETTLE: begin
        if (scnt == S_LAST) begin
          if (bus.req[sel]) begin
            state_d = GRANT;
            last_d  = sel;
            hcnt_d  = '0;
          end else if (|bus.req) begin
            sel_d  = pick(bus.req, last);
            scnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          scnt_d = scnt + 4'd1;
        end
      end
      GRANT: begin
        if (!bus.req[sel]) begin
          if (|others) begin
            state_d = SETTLE;
            sel_d   = pick(bus.req, last);
            scnt_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (hcnt == H_LAST && |others) begin
          state_d = SETTLE;
          sel_d   = pick(bus.req, last);
          scnt_d  = '0;
        end else if (hcnt != H_MAX) begin
          hcnt_d = hcnt + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    en_n_d = (state_d != GRANT);
    gnt_d  = (state_d == GRANT) ? (4'b0001 << sel_d) : 4'b0000;
    busy_d = (state_d != IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      sel   <= 2'd0;
      last  <= 2'd3;
      scnt  <= '0;
      hcnt  <= '0;
      en_n  <= 1'b1;
      gnt   <= 4'b0000;
      busy  <= 1'b0;
    end else begin
      state <= state_d;
      sel   <= sel_d;
      last  <= last_d;
      scnt  <= scnt_d;
      hcnt  <= hcnt_d;
      en_n  <= en_n_d;
      gnt   <= gnt_d;
      busy  <= busy_d;
    end
  end

  assign bus.sel_a    = sel[0];
  assign bus.sel_b    = sel[1];
  assign bus.enable_n = en_n;
  assign bus.grant    = gnt;
  assign bus.busy     = busy;

endmodule

// File: tb/tb_mux153_bus_arbiter.sv
// Directed bench for mux153_bus_arbiter with a cycle model
// of the round-robin / break-before-make rules.
module tb_mux153_bus_arbiter;

  localparam int SC = 1;
  localparam int MH = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  mux153_bus_arbiter_if bus();

  mux153_bus_arbiter #(
    .SETTLE_CYCLES(SC),
    .MAX_HOLD(MH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(
    input string       name,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, got, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 settling, 2 strobe on.
  int m_ph   = 0;
  int m_tgt  = 0;
  int m_last = 3;
  int m_cnt  = 0;
  int m_hold = 0;
  bit m_ok   = 1'b0;

  function automatic int mpick(input logic [3:0] r, input int l);
    for (int k = 1; k <= 4; k++) begin
      if (r[(l + k) % 4]) return (l + k) % 4;
    end
    return l;
  endfunction

  always @(posedge clk) begin
    logic [3:0] r;
    logic [3:0] oth;
    int         done;
    r = bus.req;
    if (!reset_n) begin
      m_ph   = 0;
      m_tgt  = 0;
      m_last = 3;
      m_cnt  = 0;
      m_hold = 0;
      m_ok   = 1'b1;
    end else begin
      case (m_ph)
        0: begin
          if (r != 4'b0) begin
            m_ph  = 1;
            m_tgt = mpick(r, m_last);
            m_cnt = 0;
          end
        end
        1: begin
          m_cnt++;
          if (m_cnt == SC) begin
            if (r[m_tgt]) begin
              m_ph   = 2;
              m_last = m_tgt;
              m_hold = 0;
            end else if (r != 4'b0) begin
              m_tgt = mpick(r, m_last);
              m_cnt = 0;
            end else begin
              m_ph = 0;
            end
          end
        end
        default: begin
          oth  = r;
          oth[m_tgt] = 1'b0;
          done = m_hold + 1;
          if (!r[m_tgt] || (done == MH && oth != 4'b0)) begin
            if (oth != 4'b0) begin
              m_ph  = 1;
              m_tgt = mpick(r, m_last);
              m_cnt = 0;
            end else begin
              m_ph = 0;
            end
          end else begin
            m_hold = (done > MH) ? MH : done;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_enable_n", 32'(bus.enable_n), (m_ph == 2) ? 32'd0 : 32'd1);
      chk("m_grant", 32'(bus.grant),
          (m_ph == 2) ? (32'd1 << m_tgt) : 32'd0);
      chk("m_sel", 32'({bus.sel_b, bus.sel_a}), 32'(m_tgt));
      chk("m_busy", 32'(bus.busy), (m_ph != 0) ? 32'd1 : 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] rr_exp [25];

  initial begin
    rr_exp = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1,
               4'h0, 4'h2, 4'h2, 4'h2, 4'h2,
               4'h0, 4'h4, 4'h4, 4'h4, 4'h4,
               4'h0, 4'h8, 4'h8, 4'h8, 4'h8,
               4'h0, 4'h1, 4'h1, 4'h1, 4'h1};
    bus.req = 4'b0000;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_en", 32'(bus.enable_n), 32'd1);
      chk("idle_grant", 32'(bus.grant), 32'd0);
    end
    chk("idle_sel", 32'({bus.sel_b, bus.sel_a}), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    bus.req = 4'b0100;
    tick();
    chk("single_sel", 32'({bus.sel_b, bus.sel_a}), 32'd2);
    chk("single_settle_en", 32'(bus.enable_n), 32'd1);
    chk("single_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("single_en", 32'(bus.enable_n), 32'd0);
    chk("single_grant", 32'(bus.grant), 32'h4);
    bus.req = 4'b0000;
    tick();
    chk("single_drop_en", 32'(bus.enable_n), 32'd1);
    chk("single_drop_busy", 32'(bus.busy), 32'd0);

    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bus.req = 4'b1111;
    for (int i = 0; i < 25; i++) begin
      tick();
      chk("rr_grant", 32'(bus.grant), 32'(rr_exp[i]));
    end

    bus.req = 4'b0000;
    tick();
    bus.req = 4'b0010;
    tick();
    chk("sole_settle_en", 32'(bus.enable_n), 32'd1);
    for (int i = 0; i < 19; i++) begin
      tick();
      chk("sole_grant", 32'(bus.grant), 32'h2);
    end

    bus.req = 4'b0000;
    tick();
    bus.req = 4'b0001;
    tick();
    tick();
    chk("o0_grant", 32'(bus.grant), 32'h1);
    bus.req = 4'b1001;
    tick();
    tick();
    bus.req = 4'b1000;
    tick();
    chk("o3_settle_en", 32'(bus.enable_n), 32'd1);
    chk("o3_settle_sel", 32'({bus.sel_b, bus.sel_a}), 32'd3);
    chk("o3_settle_grant", 32'(bus.grant), 32'd0);
    tick();
    chk("o3_grant", 32'(bus.grant), 32'h8);
    chk("o3_en", 32'(bus.enable_n), 32'd0);

    bus.req = 4'b0000;
    tick();
    bus.req = 4'b0100;
    tick();
    tick();
    chk("rst_pre_grant", 32'(bus.grant), 32'h4);
    reset_n = 1'b0;
    tick();
    chk("rst_en", 32'(bus.enable_n), 32'd1);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_sel", 32'({bus.sel_b, bus.sel_a}), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("rst_settle_en", 32'(bus.enable_n), 32'd1);
    chk("rst_settle_sel", 32'({bus.sel_b, bus.sel_a}), 32'd2);
    tick();
    chk("rst_regrant", 32'(bus.grant), 32'h4);
    chk("rst_regrant_en", 32'(bus.enable_n), 32'd0);

    bus.req = 4'b0000;
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
